// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: time-slot arbiter that multiplexes N_CH pixel-plot
// sources onto the single VGA adapter write port.
//
// Each channel owns SLOT_CYCLES consecutive clock cycles, in turn. The
// selected fields are registered, so the first cycle of every slot still
// shows the previous owner's last sample. plot_enable is forced low in that
// guard cycle so a half-switched coordinate is never written.
//
// Optional feature, macro VGA_ARB_SKIP_IDLE_EN:
//   - At slot end, ownership passes to the next requesting channel
//     (scanning circularly after the current owner).
//   - An owner that stops requesting hands off early when another channel
//     is requesting.
//   Without the macro, the rotation is a fixed round-robin and src_plot
//   only gates plot_enable.
module vga_plot_arbiter #(
    parameter int N_CH        = 8,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int C_W         = 3,
    parameter int SLOT_CYCLES = 1024
) (
    input  logic                  CLOCK_50,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [N_CH*X_W-1:0]   src_x,
    input  logic [N_CH*Y_W-1:0]   src_y,
    input  logic [N_CH*C_W-1:0]   src_color,
    input  logic [N_CH-1:0]       src_plot,
    output logic [N_CH-1:0]       grant,
    output logic                  slot_start,
    output logic [X_W-1:0]        VGA_X,
    output logic [Y_W-1:0]        VGA_Y,
    output logic [C_W-1:0]        VGA_COLOR,
    output logic                  plot_enable
);

    localparam int CUR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CUR_W-1:0] CUR_ZERO  = {CUR_W{1'b0}};
    localparam logic [CUR_W-1:0] CUR_ONE   = CUR_W'(1);
    localparam logic [N_CH-1:0]  GRANT_CH0 = N_CH'(1);

    // Plain round-robin successor, wrapping N_CH-1 back to 0.
    function automatic logic [CUR_W-1:0] rr_next(input logic [CUR_W-1:0] c);
        logic [CUR_W-1:0] n;
        if (int'(c) >= N_CH - 1) begin
            n = CUR_ZERO;
        end else begin
            n = c + CUR_ONE;
        end
        return n;
    endfunction

`ifdef VGA_ARB_SKIP_IDLE_EN
    // First requesting channel after c, scanning circularly with c itself
    // last; falls back to plain round-robin when nobody requests.
    function automatic logic [CUR_W-1:0] skip_next(input logic [CUR_W-1:0] c,
                                                   input logic [N_CH-1:0]  req);
        logic [CUR_W-1:0] n;
        logic             found;
        n     = rr_next(c);
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            int idx;
            idx = (int'(c) + i) % N_CH;
            if (!found && req[idx]) begin
                n     = CUR_W'(idx);
                found = 1'b1;
            end
        end
        return n;
    endfunction
`endif

    logic [CUR_W-1:0] cur_r;
    logic [CNT_W-1:0] slot_cnt_r;
    logic [N_CH-1:0]  grant_r;
    logic             slot_start_r;
    logic [X_W-1:0]   vga_x_r;
    logic [Y_W-1:0]   vga_y_r;
    logic [C_W-1:0]   vga_color_r;
    logic             plot_enable_r;

    logic [CUR_W-1:0] cur_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [N_CH-1:0]  grant_next_s;
    logic             slot_end_s;
    logic             early_s;
    logic             pe_next_s;
    logic [X_W-1:0]   sel_x_s;
    logic [Y_W-1:0]   sel_y_s;
    logic [C_W-1:0]   sel_color_s;

    // Slot scheduling: decide whether this edge ends the slot and who owns next.
    always_comb begin
        cur_next_s   = cur_r;
        cnt_next_s   = slot_cnt_r;
        slot_end_s   = 1'b0;
        early_s      = 1'b0;
        grant_next_s = grant_r;
        pe_next_s    = 1'b0;
        sel_x_s      = src_x[int'(cur_r)*X_W +: X_W];
        sel_y_s      = src_y[int'(cur_r)*Y_W +: Y_W];
        sel_color_s  = src_color[int'(cur_r)*C_W +: C_W];

`ifdef VGA_ARB_SKIP_IDLE_EN
        // grant_r is the one-hot of cur_r, so masking it leaves the others.
        early_s = !src_plot[cur_r] && (|(src_plot & ~grant_r));
`else
        early_s = 1'b0;
`endif

        if (en) begin
            if ((slot_cnt_r == CNT_ZERO) || early_s) begin
                slot_end_s = 1'b1;
                cnt_next_s = CNT_LOAD;
`ifdef VGA_ARB_SKIP_IDLE_EN
                cur_next_s = skip_next(cur_r, src_plot);
`else
                cur_next_s = rr_next(cur_r);
`endif
            end else begin
                slot_end_s = 1'b0;
                cnt_next_s = slot_cnt_r - CNT_ONE;
                cur_next_s = cur_r;
            end
        end else begin
            slot_end_s = 1'b0;
            cnt_next_s = slot_cnt_r;
            cur_next_s = cur_r;
        end

        grant_next_s = GRANT_CH0 << cur_next_s;
        // The slot-ending edge loads the outgoing owner's last sample: guard it.
        pe_next_s    = en && src_plot[cur_r] && !slot_end_s;
    end

    // Owner index, slot down-counter, one-hot grant and slot-start pulse.
    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            cur_r        <= CUR_ZERO;
            slot_cnt_r   <= CNT_LOAD;
            grant_r      <= GRANT_CH0;
            slot_start_r <= 1'b0;
        end else begin
            cur_r        <= cur_next_s;
            slot_cnt_r   <= cnt_next_s;
            grant_r      <= grant_next_s;
            slot_start_r <= slot_end_s;
        end
    end

    // Registered write port: fields of the pre-edge owner; held while frozen.
    always_ff @(posedge CLOCK_50 or negedge rstn) begin
        if (!rstn) begin
            vga_x_r       <= {X_W{1'b0}};
            vga_y_r       <= {Y_W{1'b0}};
            vga_color_r   <= {C_W{1'b0}};
            plot_enable_r <= 1'b0;
        end else if (en) begin
            vga_x_r       <= sel_x_s;
            vga_y_r       <= sel_y_s;
            vga_color_r   <= sel_color_s;
            plot_enable_r <= pe_next_s;
        end else begin
            plot_enable_r <= 1'b0;
        end
    end

    assign grant       = grant_r;
    assign slot_start  = slot_start_r;
    assign VGA_X       = vga_x_r;
    assign VGA_Y       = vga_y_r;
    assign VGA_COLOR   = vga_color_r;
    assign plot_enable = plot_enable_r;

endmodule
